mest_pro_host_ctrl: RTL and testbench
=====================================

Name: mest_pro_host_ctrl

Overview:
Host-side run controller for the mest_pro core, on the opposite end of its start/result interface.
- Drives mest_pro's memory-reset and start inputs in a fixed sequence.
- Buffers every valid result, with its carry and zero flags, into a FIFO that the host reads.
- Watches the core's all-done signal, with a watchdog timeout.
- Sits between the system host and mest_pro, replacing the bench-only stimulus driver in synthesizable designs.

Parameters:
- RESULT_WIDTH, 8, width of the mest_pro result bus.
- FIFO_DEPTH, 16, number of result entries buffered; power of two, at least 2.
- MEM_RESET_CYCLES, 4, cycles for which o_memory_reset is held high per run; at least 1.
- TIMEOUT_CYCLES, 65536, maximum number of RUN-state cycles before the run is aborted; at least 1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_run  in  1  host request to start a run; sampled only in IDLE.
- o_busy  out  1  high in every state except IDLE.
- o_memory_reset  out  1  to mest_pro i_memory_reset; active-high.
- o_start  out  1  to mest_pro i_start; single-cycle pulse.
- i_result  in  RESULT_WIDTH  from mest_pro o_result.
- i_valid_result  in  1  from mest_pro o_valid_result.
- i_carry  in  1  from mest_pro o_carry.
- i_zero_flag  in  1  from mest_pro o_zero_flag.
- i_all_done  in  1  from mest_pro o_all_done.
- o_rd_data  out  RESULT_WIDTH+2  head FIFO entry {carry, zero, result}.
- o_rd_valid  out  1  FIFO not empty.
- i_rd_en  in  1  pop the head entry.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_result_count  out  16  results seen in the current run, including dropped ones; saturates at 16'hFFFF.
- o_overflow  out  1  sticky; at least one result was dropped because the FIFO was full.
- o_done  out  1  sticky; the last run ended with i_all_done.
- o_timeout  out  1  sticky; the last run ended by the watchdog.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs are 0 after reset.
  - FIFO is empty and all counters are 0.
- IDLE:
  - On i_run=1, clear o_done, o_timeout, o_overflow and o_result_count.
  - Flush the FIFO, load the memory-reset counter, go to MEM_RST.
- MEM_RST:
  - o_memory_reset=1 for exactly MEM_RESET_CYCLES cycles, then go to START.
- START:
  - o_start=1 for exactly one cycle.
  - Clear the watchdog, go to RUN.
  - o_start rises 1+MEM_RESET_CYCLES cycles after the clock edge that samples i_run.
- RUN:
  - Each cycle with i_valid_result=1, push {i_carry, i_zero_flag, i_result} and increment o_result_count.
  - If the FIFO is full and no pop occurs in the same cycle, drop the entry and set o_overflow; o_result_count still increments.
  - i_all_done=1 → set o_done, go to IDLE. A result valid in the same cycle is still captured.
  - Watchdog counts RUN cycles. When it reaches TIMEOUT_CYCLES without i_all_done, set o_timeout and go to IDLE.
  - If i_all_done and the timeout occur in the same cycle, i_all_done wins: o_done=1, o_timeout=0.
- Ignored inputs:
  - i_run is ignored outside IDLE.
  - i_valid_result and i_all_done are ignored outside RUN.
- FIFO:
  - First-word fall-through: o_rd_data is valid whenever o_rd_valid=1.
  - i_rd_en while empty is ignored.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: the entry goes in and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - The host may pop in any state; the FIFO is flushed only on an accepted i_run.
- Reset mid-run: asserting i_reset_n low in any state immediately returns to IDLE with o_memory_reset=0 and o_start=0, and clears the FIFO and all flags.

Decomposition:
- Package mest_pro_host_pkg holds:
  - the state enum (IDLE, MEM_RST, START, RUN);
  - the packed result-entry struct {carry, zero, result[RESULT_WIDTH-1:0]};
  - the localparam for the result-count width (16).
- One sub-module, mest_pro_result_fifo: parameterized FWFT FIFO with push, pop, count and full/empty outputs.
- The FSM, watchdog and counters stay in the top module.

Test Plan:
- Reset → all outputs 0, o_rd_valid=0, o_fifo_count=0.
- Basic run: pulse i_run at cycle 0.
  - Expect o_memory_reset high for cycles 1–4 and o_start high at cycle 5.
  - Feed results 8'h12 (carry=1), 8'h00 (zero=1), 8'hFF, then i_all_done.
  - Expect o_done=1, o_result_count=3, and FIFO pops 10'h212, 10'h100, 10'h0FF.
- Overflow: no reads; 17 valid results 0..16 → o_overflow=1, o_fifo_count=16, o_result_count=17; pops return 0..15.
- Simultaneous push and pop on a full FIFO → count stays 16, no overflow, order preserved.
- Timeout with TIMEOUT_CYCLES=8: no i_all_done → o_timeout=1, o_done=0, return to IDLE after 8 RUN cycles.
  - Separately, i_all_done on the 8th cycle → o_done=1, o_timeout=0.
- i_run during RUN ignored. Then deassert i_reset_n mid-RUN → immediate IDLE, FIFO empty, flags 0.

Source files
------------

// File: rtl/mest_pro_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mest_pro_host_pkg
// Brief    : Shared types and constants for the mest_pro host run controller.
// Revision : 1.0 - initial release
// ============================================================================
package mest_pro_host_pkg;

   localparam int c_RESULT_COUNT_W   = 16;
   localparam int c_DEFAULT_RESULT_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEM_RST = 2'd1,
      START   = 2'd2,
      RUN     = 2'd3
   } host_state_t;

   // Entry layout at the default result width; the top re-declares it per RESULT_WIDTH.
   typedef struct packed {
      logic                          carry;
      logic                          zero;
      logic [c_DEFAULT_RESULT_W-1:0] result;
   } result_entry_t;

   function automatic logic [c_RESULT_COUNT_W-1:0] sat_inc(input logic [c_RESULT_COUNT_W-1:0] v);
      return (v == '1) ? v : v + c_RESULT_COUNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mest_pro_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mest_pro_result_fifo
// Brief    : First-word fall-through result FIFO with flush, count, full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module mest_pro_result_fifo
   import mest_pro_host_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   i_reset_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rd_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_pop;
   logic               w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (c_PTR_W+1)'(DEPTH));
   assign o_count = r_count;

   // A pop on a full FIFO frees the slot the same-cycle push needs.
   assign w_pop  = i_pop && !o_empty && !i_flush;
   assign w_push = i_push && (!o_full || w_pop) && !i_flush;

   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/mest_pro_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mest_pro_host_ctrl
// Brief    : Host run controller: sequences mest_pro, buffers results, watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mest_pro_host_ctrl
   import mest_pro_host_pkg::*;
#(
   parameter int RESULT_WIDTH     = 8,
   parameter int FIFO_DEPTH       = 16,
   parameter int MEM_RESET_CYCLES = 4,
   parameter int TIMEOUT_CYCLES   = 65536
) (
   input  logic                          clk,
   input  logic                          i_reset_n,
   input  logic                          i_run,
   output logic                          o_busy,
   output logic                          o_memory_reset,
   output logic                          o_start,
   input  logic [RESULT_WIDTH-1:0]       i_result,
   input  logic                          i_valid_result,
   input  logic                          i_carry,
   input  logic                          i_zero_flag,
   input  logic                          i_all_done,
   output logic [RESULT_WIDTH+1:0]       o_rd_data,
   output logic                          o_rd_valid,
   input  logic                          i_rd_en,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic [c_RESULT_COUNT_W-1:0]   o_result_count,
   output logic                          o_overflow,
   output logic                          o_done,
   output logic                          o_timeout
);

   localparam int c_MEM_W  = $clog2(MEM_RESET_CYCLES + 1);
   localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef struct packed {
      logic                    carry;
      logic                    zero;
      logic [RESULT_WIDTH-1:0] result;
   } entry_t;

   host_state_t                 r_state;
   logic [c_MEM_W-1:0]          r_mem_cnt;
   logic [c_WDOG_W-1:0]         r_wdog;
   logic                        r_memory_reset;
   logic                        r_start;
   logic                        r_overflow;
   logic                        r_done;
   logic                        r_timeout;
   logic [c_RESULT_COUNT_W-1:0] r_result_count;

   entry_t w_entry;
   logic   w_accept;
   logic   w_push;
   logic   w_drop;
   logic   w_full;
   logic   w_empty;

   assign w_entry  = '{carry: i_carry, zero: i_zero_flag, result: i_result};
   assign w_accept = (r_state == IDLE) && i_run;
   assign w_push   = (r_state == RUN) && i_valid_result;
   // Full implies non-empty, so any host pop frees a slot for this push.
   assign w_drop   = w_push && w_full && !i_rd_en;

   mest_pro_result_fifo #(
      .WIDTH (RESULT_WIDTH + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .i_reset_n (i_reset_n),
      .i_flush   (w_accept),
      .i_push    (w_push),
      .i_wr_data (w_entry),
      .i_pop     (i_rd_en),
      .o_rd_data (o_rd_data),
      .o_count   (o_fifo_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= IDLE;
         r_mem_cnt      <= '0;
         r_wdog         <= '0;
         r_memory_reset <= 1'b0;
         r_start        <= 1'b0;
         r_overflow     <= 1'b0;
         r_done         <= 1'b0;
         r_timeout      <= 1'b0;
         r_result_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_run) begin
                  r_done         <= 1'b0;
                  r_timeout      <= 1'b0;
                  r_overflow     <= 1'b0;
                  r_result_count <= '0;
                  r_mem_cnt      <= c_MEM_W'(MEM_RESET_CYCLES);
                  r_state        <= MEM_RST;
               end
            end
            MEM_RST: begin
               if (r_mem_cnt != '0) begin
                  r_memory_reset <= 1'b1;
                  r_mem_cnt      <= r_mem_cnt - c_MEM_W'(1);
               end else begin
                  r_memory_reset <= 1'b0;
                  r_start        <= 1'b1;
                  r_state        <= START;
               end
            end
            START: begin
               r_start <= 1'b0;
               r_wdog  <= '0;
               r_state <= RUN;
            end
            RUN: begin
               if (i_valid_result) r_result_count <= sat_inc(r_result_count);
               if (w_drop)         r_overflow     <= 1'b1;
               if (i_all_done) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else if (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_wdog <= r_wdog + c_WDOG_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy         = (r_state != IDLE);
   assign o_memory_reset = r_memory_reset;
   assign o_start        = r_start;
   assign o_rd_valid     = !w_empty;
   assign o_result_count = r_result_count;
   assign o_overflow     = r_overflow;
   assign o_done         = r_done;
   assign o_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mest_pro_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mest_pro_host_ctrl
// Brief    : Directed bench for mest_pro_host_ctrl with a phase/queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mest_pro_host_ctrl;
   import mest_pro_host_pkg::*;

   localparam int c_W     = 8;
   localparam int c_DEPTH = 16;
   localparam int c_M     = 4;
   localparam int c_T     = 24;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           i_run = 1'b0;
   logic           o_busy, o_memory_reset, o_start;
   logic [c_W-1:0] i_result = '0;
   logic           i_valid_result = 1'b0;
   logic           i_carry = 1'b0;
   logic           i_zero_flag = 1'b0;
   logic           i_all_done = 1'b0;
   logic [c_W+1:0] o_rd_data;
   logic           o_rd_valid;
   logic           i_rd_en = 1'b0;
   logic [4:0]     o_fifo_count;
   logic [15:0]    o_result_count;
   logic           o_overflow, o_done, o_timeout;

   always #5 clk = ~clk;

   mest_pro_host_ctrl #(
      .RESULT_WIDTH     (c_W),
      .FIFO_DEPTH       (c_DEPTH),
      .MEM_RESET_CYCLES (c_M),
      .TIMEOUT_CYCLES   (c_T)
   ) dut (
      .clk            (clk),
      .i_reset_n      (rst_n),
      .i_run          (i_run),
      .o_busy         (o_busy),
      .o_memory_reset (o_memory_reset),
      .o_start        (o_start),
      .i_result       (i_result),
      .i_valid_result (i_valid_result),
      .i_carry        (i_carry),
      .i_zero_flag    (i_zero_flag),
      .i_all_done     (i_all_done),
      .o_rd_data      (o_rd_data),
      .o_rd_valid     (o_rd_valid),
      .i_rd_en        (i_rd_en),
      .o_fifo_count   (o_fifo_count),
      .o_result_count (o_result_count),
      .o_overflow     (o_overflow),
      .o_done         (o_done),
      .o_timeout      (o_timeout)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: run phase = edges since the accepting edge; FIFO as a queue.
   result_entry_t m_q[$];
   bit            m_active = 1'b0;
   int            m_k = 0;
   bit            m_done = 1'b0, m_to = 1'b0, m_ovf = 1'b0;
   int            m_rc = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0; m_k = 0; m_rc = 0;
            m_done = 1'b0; m_to = 1'b0; m_ovf = 1'b0;
         end else if (!m_active && i_run) begin
            m_q.delete();
            m_active = 1'b1; m_k = 0; m_rc = 0;
            m_done = 1'b0; m_to = 1'b0; m_ovf = 1'b0;
         end else begin
            if (i_rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (m_active) begin
               if (m_k >= c_M + 2) begin
                  if (i_valid_result) begin
                     result_entry_t e;
                     e.carry  = i_carry;
                     e.zero   = i_zero_flag;
                     e.result = i_result;
                     if (m_rc < 65535) m_rc++;
                     if (m_q.size() < c_DEPTH) m_q.push_back(e);
                     else m_ovf = 1'b1;
                  end
                  if (i_all_done) begin
                     m_done = 1'b1; m_active = 1'b0;
                  end else if (m_k == c_M + 1 + c_T) begin
                     m_to = 1'b1; m_active = 1'b0;
                  end else begin
                     m_k++;
                  end
               end else begin
                  m_k++;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("busy",         32'(o_busy),         32'(m_active));
         chk("memory_reset", 32'(o_memory_reset), 32'(m_active && m_k >= 1 && m_k <= c_M));
         chk("start",        32'(o_start),        32'(m_active && m_k == c_M + 1));
         chk("rd_valid",     32'(o_rd_valid),     32'(m_q.size() > 0));
         if (m_q.size() > 0) chk("rd_data", 32'(o_rd_data), 32'(m_q[0]));
         chk("fifo_count",   32'(o_fifo_count),   m_q.size());
         chk("result_count", 32'(o_result_count), m_rc);
         chk("overflow",     32'(o_overflow),     32'(m_ovf));
         chk("done",         32'(o_done),         32'(m_done));
         chk("timeout",      32'(o_timeout),      32'(m_to));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_run();
      i_run = 1'b1;
      tick();
      i_run = 1'b0;
      for (int k = 0; k <= c_M + 1; k++) begin
         chk("seq_mem_reset", 32'(o_memory_reset), 32'(k >= 1 && k <= c_M));
         chk("seq_start",     32'(o_start),        32'(k == c_M + 1));
         tick();
      end
   endtask

   task automatic drive(input logic c, input logic z, input logic [7:0] r);
      i_valid_result = 1'b1; i_carry = c; i_zero_flag = z; i_result = r;
      tick();
      i_valid_result = 1'b0; i_carry = 1'b0; i_zero_flag = 1'b0; i_result = '0;
   endtask

   task automatic finish_run();
      i_all_done = 1'b1;
      tick();
      i_all_done = 1'b0;
   endtask

   task automatic pop_expect(input logic [9:0] exp);
      chk("pop_data", 32'(o_rd_data), 32'(exp));
      i_rd_en = 1'b1;
      tick();
      i_rd_en = 1'b0;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"},     32'(o_busy), 0);
      chk({tag, "_mr"},       32'(o_memory_reset), 0);
      chk({tag, "_start"},    32'(o_start), 0);
      chk({tag, "_rd_valid"}, 32'(o_rd_valid), 0);
      chk({tag, "_rd_data"},  32'(o_rd_data), 0);
      chk({tag, "_count"},    32'(o_fifo_count), 0);
      chk({tag, "_rcount"},   32'(o_result_count), 0);
      chk({tag, "_flags"},    32'({o_overflow, o_done, o_timeout}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got timeout, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      repeat (3) tick();
      chk_idle_zero("reset");
      rst_n = 1'b1;
      tick();

      // Basic run; the first push coincides with a pop on an empty FIFO.
      start_run();
      i_rd_en = 1'b1;
      drive(1'b1, 1'b0, 8'h12);
      i_rd_en = 1'b0;
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 8'hFF);
      finish_run();
      chk("basic_done",   32'(o_done), 1);
      chk("basic_rcount", 32'(o_result_count), 3);
      chk("basic_busy",   32'(o_busy), 0);
      pop_expect(10'h212);
      pop_expect(10'h100);
      pop_expect(10'h0FF);
      chk("basic_empty", 32'(o_rd_valid), 0);
      i_rd_en = 1'b1;
      tick();
      i_rd_en = 1'b0;
      chk("pop_empty_count", 32'(o_fifo_count), 0);

      // Overflow: 17 results, no reads.
      start_run();
      for (int i = 0; i < 17; i++) drive(1'b0, 1'b0, 8'(i));
      finish_run();
      chk("ovf_flag",   32'(o_overflow), 1);
      chk("ovf_count",  32'(o_fifo_count), 16);
      chk("ovf_rcount", 32'(o_result_count), 17);
      for (int i = 0; i < 16; i++) pop_expect(10'(i));

      // Push and pop together while full.
      start_run();
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 8'(8'h40 + i));
      for (int j = 0; j < 4; j++) begin
         chk("full_pp_head", 32'(o_rd_data), 32'(8'h40 + j));
         i_rd_en = 1'b1;
         drive(1'b0, 1'b0, 8'(8'h50 + j));
         i_rd_en = 1'b0;
         chk("full_pp_count", 32'(o_fifo_count), 16);
      end
      finish_run();
      chk("full_pp_ovf",    32'(o_overflow), 0);
      chk("full_pp_rcount", 32'(o_result_count), 20);
      for (int i = 4; i < 16; i++) pop_expect(10'(8'h40 + i));
      for (int j = 0; j < 4; j++)  pop_expect(10'(8'h50 + j));

      // Watchdog expiry after c_T RUN cycles.
      start_run();
      for (int n = 0; n < c_T; n++) begin
         chk("to_busy",  32'(o_busy), 1);
         chk("to_early", 32'(o_timeout), 0);
         tick();
      end
      chk("to_busy_end", 32'(o_busy), 0);
      chk("to_flag",     32'(o_timeout), 1);
      chk("to_done",     32'(o_done), 0);

      // all_done on the last watchdog cycle wins.
      start_run();
      repeat (c_T - 1) tick();
      finish_run();
      chk("race_done",    32'(o_done), 1);
      chk("race_timeout", 32'(o_timeout), 0);
      chk("race_busy",    32'(o_busy), 0);

      // i_run during RUN is ignored, then reset mid-run.
      start_run();
      i_run = 1'b1;
      tick();
      i_run = 1'b0;
      drive(1'b1, 1'b1, 8'hA5);
      chk("midrun_busy",  32'(o_busy), 1);
      chk("midrun_count", 32'(o_fifo_count), 1);
      chk("midrun_data",  32'(o_rd_data), 32'h3A5);
      #2 rst_n = 1'b0;
      #1 chk_idle_zero("async_rst");
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
